// File: rtl/rv_hazard_ctrl_pkg.sv
// Shared types for the execute-stage bypass scheduler: bypass select vector, stage entry,
// and the producer/consumer match rule used by every operand.
package rv_hazard_ctrl_pkg;

  // Register index width; the top-level REG_AW parameter must agree with this.
  localparam int unsigned RegAw = 5;

  typedef struct packed {
    logic alu2;
    logic write;
    logic wr_back;
  } ctrl_rs_bp_t;

  typedef struct packed {
    logic             valid;
    logic [RegAw-1:0] rd;
    logic             rd_wr;
    logic             load;
  } rv_hz_entry_t;

  localparam rv_hz_entry_t Bubble = '0;

  // x0 is hard-wired, so a producer targeting it never forwards.
  function automatic logic entry_hit(rv_hz_entry_t e, logic [RegAw-1:0] rs, logic rs_use);
    return rs_use && e.valid && e.rd_wr && (e.rd != '0) && (e.rd == rs);
  endfunction

endpackage

// File: rtl/rv_hazard_match.sv
// Per-operand bypass select: compares one source index against the three producer stages
// and returns a one-hot (youngest wins) or all-zero select.
module rv_hazard_match
  import rv_hazard_ctrl_pkg::*;
(
  input  logic [RegAw-1:0] rs_i,
  input  logic             rs_use_i,
  input  rv_hz_entry_t     ex_i,
  input  rv_hz_entry_t     alu2_i,
  input  rv_hz_entry_t     wr_i,
  output ctrl_rs_bp_t      bp_o
);

  logic unused_load;
  assign unused_load = ^{ex_i.load, alu2_i.load, wr_i.load};

  // Producer positions shift one stage by the time the consumer reaches EX.
  always_comb begin
    bp_o = '0;
    if (entry_hit(ex_i, rs_i, rs_use_i)) begin
      bp_o.alu2 = 1'b1;
    end else if (entry_hit(alu2_i, rs_i, rs_use_i)) begin
      bp_o.write = 1'b1;
    end else if (entry_hit(wr_i, rs_i, rs_use_i)) begin
      bp_o.wr_back = 1'b1;
    end
  end

endmodule

// File: rtl/rv_hazard_ctrl.sv
// Execute-stage bypass scheduler: tracks in-flight destinations, registers per-operand bypass
// selects alongside the EX pipeline register, and stalls decode on load-use hazards.
module rv_hazard_ctrl
  import rv_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = RegAw,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_dec_valid,
  input  logic [REG_AW-1:0] i_dec_rs1,
  input  logic [REG_AW-1:0] i_dec_rs2,
  input  logic              i_dec_rs1_use,
  input  logic              i_dec_rs2_use,
  input  logic [REG_AW-1:0] i_dec_rd,
  input  logic              i_dec_rd_wr,
  input  logic              i_dec_load,
  output ctrl_rs_bp_t       o_bp1,
  output ctrl_rs_bp_t       o_bp2,
  output logic              o_dec_stall,
  output logic [CNT_W-1:0]  o_luse_cnt
);

  // The WR_BACK occupant retires before any consumer now in decode reaches EX, so only
  // EX, ALU2 and WRITE need to be tracked as producers.
  rv_hz_entry_t     ex_q, alu2_q, wr_q;
  rv_hz_entry_t     dec_entry;
  ctrl_rs_bp_t      bp1_d, bp2_d, bp1_q, bp2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rs1_use, rs2_use, luse;

  assign rs1_use = i_dec_valid & i_dec_rs1_use;
  assign rs2_use = i_dec_valid & i_dec_rs2_use;

  always_comb begin
    dec_entry = Bubble;
    if (i_dec_valid) begin
      dec_entry.valid = 1'b1;
      dec_entry.rd    = i_dec_rd;
      dec_entry.rd_wr = i_dec_rd_wr;
      dec_entry.load  = i_dec_load;
    end
  end

  rv_hazard_match u_match_rs1 (
    .rs_i    (i_dec_rs1),
    .rs_use_i(rs1_use),
    .ex_i    (ex_q),
    .alu2_i  (alu2_q),
    .wr_i    (wr_q),
    .bp_o    (bp1_d)
  );

  rv_hazard_match u_match_rs2 (
    .rs_i    (i_dec_rs2),
    .rs_use_i(rs2_use),
    .ex_i    (ex_q),
    .alu2_i  (alu2_q),
    .wr_i    (wr_q),
    .bp_o    (bp2_d)
  );

  // Load data is not available until WRITE, so a consumer directly behind a load must wait.
  assign luse = ex_q.load &
                (entry_hit(ex_q, i_dec_rs1, rs1_use) | entry_hit(ex_q, i_dec_rs2, rs2_use));
  assign o_dec_stall = luse & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_q   <= Bubble;
      alu2_q <= Bubble;
      wr_q   <= Bubble;
      bp1_q  <= '0;
      bp2_q  <= '0;
      cnt_q  <= '0;
    end else if (!i_stall) begin
      wr_q <= alu2_q;
      if (i_flush) begin
        ex_q   <= Bubble;
        alu2_q <= Bubble;
        bp1_q  <= '0;
        bp2_q  <= '0;
      end else if (luse) begin
        alu2_q <= ex_q;
        ex_q   <= Bubble;
        bp1_q  <= '0;
        bp2_q  <= '0;
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        alu2_q <= ex_q;
        ex_q   <= dec_entry;
        bp1_q  <= bp1_d;
        bp2_q  <= bp2_d;
      end
    end
  end

  assign o_bp1      = bp1_q;
  assign o_bp2      = bp2_q;
  assign o_luse_cnt = cnt_q;

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Self-checking bench for rv_hazard_ctrl: short instruction sequences with expected selects
// queued at drive time and compared after the following clock edge.
module tb_rv_hazard_ctrl;
  import rv_hazard_ctrl_pkg::*;

  localparam int unsigned CntW = 2;
  localparam logic [2:0] BpNone = 3'b000;
  localparam logic [2:0] BpAlu2 = 3'b100;
  localparam logic [2:0] BpWr   = 3'b010;
  localparam logic [2:0] BpWb   = 3'b001;

  logic            clk;
  logic            reset, stall, flush;
  logic            dec_valid, rs1_use, rs2_use, rd_wr, load;
  logic [4:0]      rs1, rs2, rd;
  ctrl_rs_bp_t     bp1, bp2;
  logic            dec_stall;
  logic [CntW-1:0] luse_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    string           tag;
    logic [2:0]      bp1;
    logic [2:0]      bp2;
    logic [CntW-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  rv_hazard_ctrl #(
    .REG_AW(5),
    .CNT_W (CntW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_dec_valid  (dec_valid),
    .i_dec_rs1    (rs1),
    .i_dec_rs2    (rs2),
    .i_dec_rs1_use(rs1_use),
    .i_dec_rs2_use(rs2_use),
    .i_dec_rd     (rd),
    .i_dec_rd_wr  (rd_wr),
    .i_dec_load   (load),
    .o_bp1        (bp1),
    .o_bp2        (bp2),
    .o_dec_stall  (dec_stall),
    .o_luse_cnt   (luse_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // One decode cycle: drive, check the combinational stall, queue the registered expectation,
  // clock, then pop and compare.
  task automatic cyc(input string tag, input logic v, input logic [4:0] d, input logic w,
                     input logic l, input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                     input logic u2, input logic es, input logic [2:0] e1, input logic [2:0] e2,
                     input logic [CntW-1:0] ec);
    exp_t e;
    dec_valid = v;
    rd        = d;
    rd_wr     = w;
    load      = l;
    rs1       = s1;
    rs1_use   = u1;
    rs2       = s2;
    rs2_use   = u2;
    #1;
    if (!reset) check({tag, ".stall"}, 32'(dec_stall), 32'(es));
    e.tag = tag;
    e.bp1 = e1;
    e.bp2 = e2;
    e.cnt = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".bp1"}, 32'(bp1), 32'(e.bp1));
    check({e.tag, ".bp2"}, 32'(bp2), 32'(e.bp2));
    check({e.tag, ".cnt"}, 32'(luse_cnt), 32'(e.cnt));
  endtask

  task automatic alu(input string tag, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic es, input logic [2:0] e1,
                     input logic [2:0] e2, input logic [CntW-1:0] ec);
    cyc(tag, 1'b1, d, 1'b1, 1'b0, s1, 1'b1, s2, 1'b1, es, e1, e2, ec);
  endtask

  task automatic lw(input string tag, input logic [4:0] d, input logic [4:0] s1,
                    input logic [CntW-1:0] ec);
    cyc(tag, 1'b1, d, 1'b1, 1'b1, s1, 1'b1, 5'd0, 1'b0, 1'b0, BpNone, BpNone, ec);
  endtask

  task automatic bub(input string tag, input logic [CntW-1:0] ec);
    cyc(tag, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, BpNone, BpNone, ec);
  endtask

  task automatic drain(input logic [CntW-1:0] ec);
    repeat (4) bub("drain", ec);
  endtask

  // Load followed by a dependent add: one stall cycle, bubble, then forwarding from WRITE.
  task automatic luse_pair(input string tag, input logic [CntW-1:0] c0,
                           input logic [CntW-1:0] c1);
    lw({tag, "_lw"}, 5'd8, 5'd1, c0);
    alu({tag, "_stall"}, 5'd9, 5'd8, 5'd8, 1'b1, BpNone, BpNone, c1);
    alu({tag, "_fwd"}, 5'd9, 5'd8, 5'd8, 1'b0, BpWr, BpWr, c1);
    drain(c1);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    bub("reset0", 2'd0);
    bub("reset1", 2'd0);
    reset = 1'b0;
    bub("idle", 2'd0);

    // Back-to-back dependency forwards from ALU2.
    alu("s1_prod", 5'd5, 5'd1, 5'd2, 1'b0, BpNone, BpNone, 2'd0);
    alu("s1_cons", 5'd6, 5'd5, 5'd1, 1'b0, BpAlu2, BpNone, 2'd0);
    drain(2'd0);

    // Increasing distance: WRITE, WR_BACK, then register file.
    alu("s2a_prod", 5'd5, 5'd1, 5'd2, 1'b0, BpNone, BpNone, 2'd0);
    bub("s2a_nop", 2'd0);
    alu("s2_wr", 5'd7, 5'd2, 5'd5, 1'b0, BpNone, BpWr, 2'd0);
    drain(2'd0);
    alu("s2b_prod", 5'd5, 5'd1, 5'd2, 1'b0, BpNone, BpNone, 2'd0);
    repeat (2) bub("s2b_nop", 2'd0);
    alu("s2_wb", 5'd7, 5'd2, 5'd5, 1'b0, BpNone, BpWb, 2'd0);
    drain(2'd0);
    alu("s2c_prod", 5'd5, 5'd1, 5'd2, 1'b0, BpNone, BpNone, 2'd0);
    repeat (3) bub("s2c_nop", 2'd0);
    alu("s2_rf", 5'd7, 5'd2, 5'd5, 1'b0, BpNone, BpNone, 2'd0);
    drain(2'd0);

    luse_pair("s3", 2'd0, 2'd1);

    // x0 never forwards; youngest of two writers wins.
    alu("s4_x0", 5'd0, 5'd1, 5'd2, 1'b0, BpNone, BpNone, 2'd1);
    alu("s4_use0", 5'd3, 5'd0, 5'd0, 1'b0, BpNone, BpNone, 2'd1);
    drain(2'd1);
    alu("s4_old", 5'd5, 5'd1, 5'd2, 1'b0, BpNone, BpNone, 2'd1);
    alu("s4_new", 5'd5, 5'd3, 5'd4, 1'b0, BpNone, BpNone, 2'd1);
    alu("s4_young", 5'd6, 5'd5, 5'd5, 1'b0, BpAlu2, BpAlu2, 2'd1);
    drain(2'd1);

    // Flush on the would-be stall cycle kills the load and suppresses the stall.
    lw("s5_lw", 5'd8, 5'd1, 2'd1);
    flush = 1'b1;
    alu("s5_flush", 5'd9, 5'd8, 5'd1, 1'b0, BpNone, BpNone, 2'd1);
    flush = 1'b0;
    alu("s5_after", 5'd9, 5'd8, 5'd1, 1'b0, BpNone, BpNone, 2'd1);
    drain(2'd1);

    // Global stall holds selects and pipeline contents.
    alu("s6_prod", 5'd5, 5'd1, 5'd2, 1'b0, BpNone, BpNone, 2'd1);
    alu("s6_fwd", 5'd6, 5'd5, 5'd1, 1'b0, BpAlu2, BpNone, 2'd1);
    stall = 1'b1;
    repeat (3) alu("s6_hold", 5'd7, 5'd2, 5'd2, 1'b0, BpAlu2, BpNone, 2'd1);
    stall = 1'b0;
    alu("s6_resume", 5'd7, 5'd5, 5'd6, 1'b0, BpWr, BpAlu2, 2'd1);
    drain(2'd1);

    // Global stall on top of a load-use: stall visible, counter frozen until release.
    lw("s6l_lw", 5'd8, 5'd1, 2'd1);
    stall = 1'b1;
    alu("s6l_hold", 5'd9, 5'd8, 5'd8, 1'b1, BpNone, BpNone, 2'd1);
    stall = 1'b0;
    alu("s6l_stall", 5'd9, 5'd8, 5'd8, 1'b1, BpNone, BpNone, 2'd2);
    alu("s6l_fwd", 5'd9, 5'd8, 5'd8, 1'b0, BpWr, BpWr, 2'd2);
    drain(2'd2);

    // Counter saturates at all-ones.
    luse_pair("sat1", 2'd2, 2'd3);
    luse_pair("sat2", 2'd3, 2'd3);

    // Invalid decode never stalls or selects, even with matching fields.
    lw("s8_lw", 5'd8, 5'd1, 2'd3);
    cyc("s8_inval", 1'b0, 5'd9, 1'b1, 1'b0, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, BpNone, BpNone,
        2'd3);
    alu("s8_fwd", 5'd9, 5'd8, 5'd8, 1'b0, BpWr, BpWr, 2'd3);
    drain(2'd3);

    // Reset in the middle of a load-use clears everything.
    lw("s7_lw", 5'd8, 5'd1, 2'd3);
    reset = 1'b1;
    alu("s7_rst", 5'd9, 5'd8, 5'd8, 1'b0, BpNone, BpNone, 2'd0);
    reset = 1'b0;
    alu("s7_after", 5'd9, 5'd8, 5'd8, 1'b0, BpNone, BpNone, 2'd0);
    drain(2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
